// File: rtl/sha256d_nonce_sched.sv
// Nonce sweep scheduler for an external SHA-256d hasher: serves header words
// plus the byte-swapped nonce on request and checks each result for leading zero bits.
module sha256d_nonce_sched #(
  parameter int unsigned HDR_WORDS = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hdr_we,
  input  logic [4:0]   hdr_addr,
  input  logic [31:0]  hdr_wdata,
  input  logic         go,
  input  logic         stop,
  input  logic [31:0]  nonce_first,
  input  logic [31:0]  nonce_last,
  input  logic [7:0]   zbits,
  output logic         h_start,
  output logic         h_rdy,
  output logic [31:0]  h_data,
  input  logic         h_rq,
  input  logic [4:0]   h_addr,
  input  logic         h_done,
  input  logic [255:0] h_hash,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic         stopped,
  output logic [31:0]  found_nonce,
  output logic [31:0]  cur_nonce
);

  typedef enum logic [1:0] {IDLE, LAUNCH, SERVE, CHECK} state_t;

  state_t         state, state_d;
  logic [31:0]    hdr [HDR_WORDS];
  logic [255:0]   hash_q;
  logic           abort_q, abort_d;
  logic           rq_q;
  logic           busy_d, found_d, exh_d, stopped_d;
  logic [31:0]    cur_d, fnonce_d;
  logic           serve, capture, match;
  logic [255:0]   zmask;
  logic [31:0]    word;

  // Mask covers the top zbits bits of the hash; zbits==0 yields an empty mask.
  assign zmask = ~({256{1'b1}} >> zbits);
  assign match = (hash_q & zmask) == '0;

  always_comb begin
    word = '0;
    if (32'(h_addr) < HDR_WORDS)
      word = hdr[h_addr];
    else if (32'(h_addr) == HDR_WORDS)
      word = {cur_nonce[7:0], cur_nonce[15:8], cur_nonce[23:16], cur_nonce[31:24]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < HDR_WORDS; i++) hdr[i] <= '0;
    end else if (hdr_we && !busy && 32'(hdr_addr) < HDR_WORDS) begin
      hdr[hdr_addr] <= hdr_wdata;
    end
  end

  always_comb begin
    state_d   = state;
    busy_d    = busy;
    found_d   = found;
    exh_d     = exhausted;
    stopped_d = stopped;
    abort_d   = abort_q;
    cur_d     = cur_nonce;
    fnonce_d  = found_nonce;
    serve     = 1'b0;
    capture   = 1'b0;
    h_start   = 1'b0;
    if (busy && stop) abort_d = 1'b1;
    case (state)
      IDLE: begin
        if (go) begin
          state_d   = LAUNCH;
          cur_d     = nonce_first;
          found_d   = 1'b0;
          exh_d     = 1'b0;
          stopped_d = 1'b0;
          abort_d   = 1'b0;
          busy_d    = 1'b1;
        end
      end
      LAUNCH: begin
        h_start = 1'b1;
        state_d = SERVE;
      end
      SERVE: begin
        serve = h_rq && !rq_q;
        if (h_done) begin
          capture = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // A match wins over a pending abort so a found nonce is never discarded.
        if (match) begin
          found_d  = 1'b1;
          fnonce_d = cur_nonce;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else if (abort_q) begin
          stopped_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else if (cur_nonce == nonce_last) begin
          exh_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cur_d   = cur_nonce + 32'd1;
          state_d = LAUNCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      stopped     <= 1'b0;
      abort_q     <= 1'b0;
      rq_q        <= 1'b0;
      h_rdy       <= 1'b0;
      h_data      <= '0;
      hash_q      <= '0;
      cur_nonce   <= '0;
      found_nonce <= '0;
    end else begin
      state       <= state_d;
      busy        <= busy_d;
      found       <= found_d;
      exhausted   <= exh_d;
      stopped     <= stopped_d;
      abort_q     <= abort_d;
      rq_q        <= h_rq;
      h_rdy       <= serve;
      cur_nonce   <= cur_d;
      found_nonce <= fnonce_d;
      if (serve) h_data <= word;
      if (capture) hash_q <= h_hash;
    end
  end

endmodule

// File: tb/tb_sha256d_nonce_sched.sv
// Directed bench for sha256d_nonce_sched with a behavioural hasher model.
module tb_sha256d_nonce_sched;
  localparam int unsigned HW = 19;
  localparam logic [255:0] NOMATCH = {1'b1, 255'b0};
  localparam logic [255:0] MH8     = {8'h00, {248{1'b1}}};

  logic         clk = 1'b0;
  logic         rst, hdr_we, go, stop, h_rq, h_done;
  logic [4:0]   hdr_addr, h_addr;
  logic [31:0]  hdr_wdata, nonce_first, nonce_last;
  logic [7:0]   zbits;
  logic [255:0] h_hash;
  logic         h_start, h_rdy, busy, found, exhausted, stopped;
  logic [31:0]  h_data, found_nonce, cur_nonce;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned starts = 0;
  logic [31:0] hdr_m [HW];

  typedef struct {
    logic [31:0]  first, last;
    logic [7:0]   zb;
    logic         match_en;
    logic [31:0]  match_n;
    logic [255:0] mhash;
    int unsigned  stop_hash;
    logic         stop_at_done;
    logic         exp_found, exp_exh, exp_stp;
    logic [31:0]  exp_fnonce, exp_cur;
    int unsigned  exp_starts;
  } vec_t;

  vec_t vecs [9];

  sha256d_nonce_sched #(.HDR_WORDS(HW)) dut (
    .clk(clk), .rst(rst), .hdr_we(hdr_we), .hdr_addr(hdr_addr), .hdr_wdata(hdr_wdata),
    .go(go), .stop(stop), .nonce_first(nonce_first), .nonce_last(nonce_last), .zbits(zbits),
    .h_start(h_start), .h_rdy(h_rdy), .h_data(h_data), .h_rq(h_rq), .h_addr(h_addr),
    .h_done(h_done), .h_hash(h_hash), .busy(busy), .found(found), .exhausted(exhausted),
    .stopped(stopped), .found_nonce(found_nonce), .cur_nonce(cur_nonce)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (h_start) starts++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] f, input logic [31:0] l, input logic [7:0] zb,
                               input logic me, input logic [31:0] mn, input logic [255:0] mh,
                               input int unsigned sh, input logic sd,
                               input logic ef, input logic ee, input logic es,
                               input logic [31:0] efn, input logic [31:0] ec, input int unsigned est);
    vec_t v;
    v.first = f; v.last = l; v.zb = zb; v.match_en = me; v.match_n = mn; v.mhash = mh;
    v.stop_hash = sh; v.stop_at_done = sd; v.exp_found = ef; v.exp_exh = ee; v.exp_stp = es;
    v.exp_fnonce = efn; v.exp_cur = ec; v.exp_starts = est;
    return v;
  endfunction

  function automatic logic [31:0] exp_word(input int unsigned a, input logic [31:0] n);
    if (a < HW) return hdr_m[a];
    if (a == HW) return {n[7:0], n[15:8], n[23:16], n[31:24]};
    return 32'h0;
  endfunction

  // Called at a negedge with SERVE active; returns two negedges later with h_rq low.
  task automatic req_word(input int unsigned a, input logic [31:0] exp);
    h_rq = 1'b1; h_addr = 5'(a);
    @(negedge clk);
    chk("h_rdy_pulse", 32'(h_rdy), 32'd1);
    chk("h_data", h_data, exp);
    h_rq = 1'b0;
    @(negedge clk);
    chk("h_rdy_drop", 32'(h_rdy), 32'd0);
  endtask

  task automatic do_hash(input vec_t v, input logic [31:0] n, input int unsigned idx);
    @(negedge clk);
    chk("h_start_one_cycle", 32'(h_start), 32'd0);
    chk("cur_nonce_in_hash", cur_nonce, n);
    for (int unsigned a = 0; a <= HW; a++) begin
      if (v.stop_hash == idx && !v.stop_at_done && a == 5) stop = 1'b1;
      req_word(a, exp_word(a, n));
      stop = 1'b0;
    end
    h_done = 1'b1;
    h_hash = (v.match_en && n == v.match_n) ? v.mhash : NOMATCH;
    if (v.stop_hash == idx && v.stop_at_done) stop = 1'b1;
    @(negedge clk);
    h_done = 1'b0;
    stop = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    logic [31:0] n;
    int unsigned idx, s0, guard;
    logic done;
    n = v.first; idx = 0; done = 1'b0;
    s0 = starts;
    nonce_first = v.first; nonce_last = v.last; zbits = v.zb; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk({nm, " busy_after_go"}, 32'(busy), 32'd1);
    while (!done) begin
      guard = 0;
      while (!h_start && busy && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      if (h_start && idx < 12) begin
        idx++;
        do_hash(v, n, idx);
        n = n + 32'd1;
      end else begin
        done = 1'b1;
        if (busy) begin
          chk({nm, " sweep_bound"}, 32'(busy), 32'd0);
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
        end
      end
    end
    chk({nm, " busy_end"}, 32'(busy), 32'd0);
    chk({nm, " found"}, 32'(found), 32'(v.exp_found));
    chk({nm, " exhausted"}, 32'(exhausted), 32'(v.exp_exh));
    chk({nm, " stopped"}, 32'(stopped), 32'(v.exp_stp));
    chk({nm, " cur_nonce"}, cur_nonce, v.exp_cur);
    chk({nm, " h_start_count"}, starts - s0, v.exp_starts);
    if (v.exp_found) chk({nm, " found_nonce"}, found_nonce, v.exp_fnonce);
  endtask

  initial begin
    int unsigned r, guard;
    rst = 1'b1; hdr_we = 1'b0; go = 1'b0; stop = 1'b0; h_rq = 1'b0; h_done = 1'b0;
    hdr_addr = '0; h_addr = '0; hdr_wdata = '0; nonce_first = '0; nonce_last = '0;
    zbits = '0; h_hash = '0;
    for (int unsigned i = 0; i < HW; i++) hdr_m[i] = 32'(i);

    vecs[0] = mkv(32'h11223344, 32'h11223344, 8'd0,   1'b0, 32'h0, NOMATCH, 0, 1'b0,
                  1'b1, 1'b0, 1'b0, 32'h11223344, 32'h11223344, 1);
    vecs[1] = mkv(32'd5, 32'd9, 8'd8, 1'b1, 32'd7, MH8, 0, 1'b0,
                  1'b1, 1'b0, 1'b0, 32'd7, 32'd7, 3);
    vecs[2] = mkv(32'hFFFFFFFE, 32'h1, 8'd8, 1'b0, 32'h0, NOMATCH, 0, 1'b0,
                  1'b0, 1'b1, 1'b0, 32'h0, 32'h1, 4);
    vecs[3] = mkv(32'd0, 32'd100, 8'd8, 1'b0, 32'h0, NOMATCH, 2, 1'b0,
                  1'b0, 1'b0, 1'b1, 32'h0, 32'd1, 2);
    vecs[4] = mkv(32'd10, 32'd12, 8'd255, 1'b1, 32'd12, 256'h1, 0, 1'b0,
                  1'b1, 1'b0, 1'b0, 32'd12, 32'd12, 3);
    vecs[5] = mkv(32'd30, 32'd31, 8'd9, 1'b1, 32'd30, MH8, 0, 1'b0,
                  1'b0, 1'b1, 1'b0, 32'h0, 32'd31, 2);
    vecs[6] = mkv(32'd40, 32'd50, 8'd8, 1'b0, 32'h0, NOMATCH, 1, 1'b1,
                  1'b0, 1'b0, 1'b1, 32'h0, 32'd40, 1);
    vecs[7] = mkv(32'd60, 32'd70, 8'd8, 1'b1, 32'd60, MH8, 1, 1'b1,
                  1'b1, 1'b0, 1'b0, 32'd60, 32'd60, 1);
    vecs[8] = mkv(32'd20, 32'd20, 8'd1, 1'b0, 32'h0, NOMATCH, 0, 1'b0,
                  1'b0, 1'b1, 1'b0, 32'h0, 32'd20, 1);

    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst found", 32'(found), 32'd0);
    chk("rst exhausted", 32'(exhausted), 32'd0);
    chk("rst stopped", 32'(stopped), 32'd0);
    chk("rst h_start", 32'(h_start), 32'd0);
    chk("rst h_rdy", 32'(h_rdy), 32'd0);
    chk("rst h_data", h_data, 32'h0);
    chk("rst cur_nonce", cur_nonce, 32'h0);
    chk("rst found_nonce", found_nonce, 32'h0);
    rst = 1'b0;

    for (int unsigned i = 0; i < HW; i++) begin
      hdr_we = 1'b1; hdr_addr = 5'(i); hdr_wdata = 32'(i);
      @(negedge clk);
    end
    hdr_addr = 5'd19; hdr_wdata = 32'hBADBAD19;
    @(negedge clk);
    hdr_addr = 5'd31; hdr_wdata = 32'hBADBAD31;
    @(negedge clk);
    hdr_we = 1'b0;

    for (int unsigned k = 0; k < 9; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Held request and blocked header write while busy.
    nonce_first = 32'h55; nonce_last = 32'h55; zbits = 8'd0; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk("hold h_start", 32'(h_start), 32'd1);
    @(negedge clk);
    h_rq = 1'b1; h_addr = 5'd3;
    hdr_we = 1'b1; hdr_addr = 5'd3; hdr_wdata = 32'hDEADBEEF;
    r = 0;
    for (int unsigned c = 0; c < 10; c++) begin
      @(negedge clk);
      if (h_rdy) r++;
      chk("hold h_data", h_data, 32'd3);
    end
    chk("hold rdy_count", r, 32'd1);
    h_rq = 1'b0; hdr_we = 1'b0;
    @(negedge clk);
    chk("hold h_data_stable", h_data, 32'd3);
    req_word(3, 32'd3);
    req_word(25, 32'h0);
    h_done = 1'b1; h_hash = NOMATCH;
    @(negedge clk);
    h_done = 1'b0;
    guard = 0;
    while (busy && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("hold found", 32'(found), 32'd1);
    chk("hold found_nonce", found_nonce, 32'h55);

    // Reset in the middle of SERVE.
    nonce_first = 32'h100; nonce_last = 32'h200; zbits = 8'd8; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    req_word(0, 32'd0);
    h_rq = 1'b1; h_addr = 5'd1; rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst h_rdy", 32'(h_rdy), 32'd0);
    chk("midrst found", 32'(found), 32'd0);
    chk("midrst cur_nonce", cur_nonce, 32'h0);
    chk("midrst h_data", h_data, 32'h0);
    rst = 1'b0; h_rq = 1'b0;
    for (int unsigned i = 0; i < HW; i++) hdr_m[i] = 32'h0;
    @(negedge clk);
    run_vec(mkv(32'h300, 32'h300, 8'd0, 1'b0, 32'h0, NOMATCH, 0, 1'b0,
                1'b1, 1'b0, 1'b0, 32'h300, 32'h300, 1), "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
